// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// reset PC default and the nop substituted for faulting fetches.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_HALT = 3'd4
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Free-running 64-bit event counter: increments when i_en is high, wraps at 2^W.
module ifu_perf_cnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time and
// holds the result for the decoder. Macro IFU_PERF_EN adds fetch/stall counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  input  logic            resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
`ifdef IFU_PERF_EN
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt,
`endif
  output logic            halted
);

  ifu_state_e      r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next, r_req_addr, r_inst, r_out_pc, w_redir_pc;
  logic            r_fault, r_drop, w_drop_next, r_halt_pend;
  logic            w_go_req, w_halt_any, w_resp_keep;

  assign w_redir_pc  = redirect_pc & ~XLEN'(3);
  assign w_halt_any  = r_halt_pend | halt;
  assign w_resp_keep = (r_state == IFU_WAIT) && resp_valid && !r_drop && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IFU_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_drop      <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_drop  <= w_drop_next;
      if (halt) begin
        r_halt_pend <= 1'b1;
      end
      // req_addr only moves on REQ entry, so it stays put while the request is pending
      if ((w_state_next == IFU_REQ) && (r_state != IFU_REQ)) begin
        r_req_addr <= w_pc_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_go_req     = 1'b0;
    case (r_state)
      IFU_IDLE: begin
        w_go_req = 1'b1;
        if (redirect_valid) w_pc_next = w_redir_pc;
      end
      IFU_REQ: begin
        if (redirect_valid) begin
          w_pc_next   = w_redir_pc;
          w_drop_next = 1'b1;
        end
        if (req_ready) w_state_next = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (resp_valid) begin
          w_drop_next = 1'b0;
          if (w_resp_keep) begin
            w_pc_next    = r_req_addr + XLEN'(4);
            w_state_next = IFU_HOLD;
          end else begin
            w_go_req = 1'b1;
            if (redirect_valid) w_pc_next = w_redir_pc;
          end
        end else if (redirect_valid) begin
          w_pc_next   = w_redir_pc;
          w_drop_next = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (redirect_valid) w_pc_next = w_redir_pc;
        if (out_ready || redirect_valid) w_go_req = 1'b1;
      end
      IFU_HALT: w_state_next = IFU_HALT;
      default:  w_state_next = IFU_IDLE;
    endcase
    // a pending halt diverts every would-be REQ entry
    if (w_go_req) w_state_next = w_halt_any ? IFU_HALT : IFU_REQ;
  end

  always_comb begin
    req_valid = (r_state == IFU_REQ);
    out_valid = (r_state == IFU_HOLD);
    halted    = (r_state == IFU_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst   <= NOP_INST;
      r_out_pc <= RESET_PC;
      r_fault  <= 1'b0;
    end else if (w_resp_keep) begin
      r_inst   <= resp_err ? NOP_INST : resp_data;
      r_out_pc <= r_req_addr;
      r_fault  <= resp_err;
    end
  end

  assign req_addr = r_req_addr;
  assign inst     = r_inst;
  assign pc       = r_out_pc;
  assign fault    = r_fault;

`ifdef IFU_PERF_EN
  logic w_fetch_fire, w_stall;
  assign w_fetch_fire = out_valid & out_ready;
  assign w_stall      = (r_state == IFU_REQ) || (r_state == IFU_WAIT);

  ifu_perf_cnt #(.W(64)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_fetch_fire),
    .o_cnt (perf_fetch_cnt)
  );

  ifu_perf_cnt #(.W(64)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall),
    .o_cnt (perf_stall_cnt)
  );
`else
  // counters absent: fetch behaviour is unchanged
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a transaction-level scoreboard model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0, resp_err = 1'b0;
  logic [31:0] resp_data = 32'hDEAD_BEEF;
  logic        out_valid, out_ready = 1'b0, fault;
  logic [31:0] inst, pc;
  logic        redirect_valid = 1'b0, halt = 1'b0, halted;
  logic [31:0] redirect_pc = 32'h0;

  int n_vec = 0, n_bad = 0;
  int mem_mode = 1;                 // 0 manual, 1 always ready, 2 ready lags req_valid by a cycle
  logic [31:0] err_addr = 32'h8000_0008;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .pc(pc), .fault(fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {22'd0, a[11:2]} + 32'd1;
    return (idx << 20) | 32'h0000_0093;
  endfunction

  // ---------------- scoreboard model ----------------
  typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic fault; } out_t;
  out_t        q[$];
  logic [31:0] m_addr = RST_PC, o_addr = 32'h0, p_req_addr = 32'h0;
  bit          outst, m_drop, halt_seen, p_req_pend, p_out_hold, p_halted;

  always @(negedge clk) begin : model
    bit drop_now;
    if (!rst) begin
      chk(!req_valid && !out_valid && !halted, "rst_ctrl", {29'd0, req_valid, out_valid, halted}, 32'd0);
      chk(req_addr == RST_PC && pc == RST_PC && inst == NOP && !fault, "rst_regs", req_addr, RST_PC);
      q.delete();
      m_addr = RST_PC; outst = 0; m_drop = 0; halt_seen = 0;
      p_req_pend = 0; p_out_hold = 0; p_halted = 0;
    end else begin
      if (halted) chk(!req_valid && !out_valid, "halt_quiet", {30'd0, req_valid, out_valid}, 32'd0);
      if (halted) chk(halt_seen, "halt_cause", 32'(halted), 32'(halt_seen));
      if (p_halted) chk(halted, "halt_sticky", 32'(halted), 32'd1);
      if (req_valid) chk(req_addr == m_addr, "req_addr", req_addr, m_addr);
      if (p_req_pend) chk(req_valid && req_addr == p_req_addr, "req_stable", req_addr, p_req_addr);
      if (p_out_hold) chk(out_valid, "out_hold", 32'(out_valid), 32'd1);
      if (out_valid) begin
        chk(q.size() != 0, "spurious_out", pc, 32'(q.size()));
        if (q.size() != 0) begin
          chk(inst == q[0].inst, "out_inst", inst, q[0].inst);
          chk(pc == q[0].pc, "out_pc", pc, q[0].pc);
          chk(fault == q[0].fault, "out_fault", 32'(fault), 32'(q[0].fault));
        end
      end
      // advance the model with the inputs the DUT samples at the coming edge
      p_req_pend = req_valid && !req_ready;
      p_req_addr = req_addr;
      p_out_hold = out_valid && !out_ready && !redirect_valid;
      p_halted   = halted;
      if (halt) halt_seen = 1;
      if (out_valid && (out_ready || redirect_valid) && q.size() != 0) void'(q.pop_front());
      drop_now = redirect_valid && (req_valid || (outst && !resp_valid));
      if (resp_valid && outst) begin
        if (!m_drop && !redirect_valid) begin
          q.push_back('{resp_err ? NOP : resp_data, o_addr, resp_err});
          m_addr = o_addr + 32'd4;
        end
        outst = 0;
        m_drop = 0;
      end
      if (req_valid && req_ready) begin
        outst  = 1;
        o_addr = req_addr;
      end
      if (redirect_valid) m_addr = redirect_pc & ~32'd3;
      if (drop_now) m_drop = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    bit acc, pre_v;
    logic [31:0] a;
    acc = req_valid && req_ready;
    pre_v = req_valid;
    a = req_addr;
    @(posedge clk);
    #2;
    resp_valid = 1'b0; resp_err = 1'b0; resp_data = 32'hDEAD_BEEF;
    redirect_valid = 1'b0; halt = 1'b0;
    if (mem_mode != 0) begin
      resp_valid = acc;
      resp_err   = acc && (a == err_addr);
      if (acc) resp_data = mem_word(a);
      req_ready = (mem_mode == 1) ? 1'b1 : pre_v;
    end
  endtask

  function automatic bit sig(input int s);
    case (s)
      0:       return req_valid;
      1:       return out_valid;
      default: return halted;
    endcase
  endfunction

  task automatic wait_sig(input int s, input string nm, output int n);
    n = 0;
    while (!sig(s) && n < 40) begin
      cycle();
      n++;
    end
    chk(sig(s), nm, 32'(n), 32'd40);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, n2;
    repeat (3) @(posedge clk);
    #2;
    req_ready = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;

    // T1: first fetch with an always-ready memory
    chk(!req_valid && req_addr == 32'h8000_0000, "t1_idle", req_addr, 32'h8000_0000);
    wait_sig(0, "t1_wait_req", n);
    chk(n == 1, "t1_idle_len", 32'(n), 32'd1);
    chk(req_addr == 32'h8000_0000, "t1_addr", req_addr, 32'h8000_0000);
    wait_sig(1, "t1_wait_out", n);
    chk(n == 2, "t1_latency", 32'(n), 32'd2);
    chk(inst == 32'h0010_0093 && pc == 32'h8000_0000 && !fault, "t1_out", inst, 32'h0010_0093);
    wait_sig(0, "t1_wait_req2", n);
    chk(req_addr == 32'h8000_0004, "t1_next_addr", req_addr, 32'h8000_0004);

    // T2: decoder stalls for 5 cycles in HOLD
    out_ready = 1'b0;
    wait_sig(1, "t2_wait_out", n);
    for (int i = 0; i < 5; i++) begin
      chk(out_valid && !req_valid, "t2_hold_ctrl", {30'd0, out_valid, req_valid}, 32'd2);
      chk(inst == 32'h0020_0093 && pc == 32'h8000_0004, "t2_hold_data", inst, 32'h0020_0093);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk(!out_valid, "t2_single_hs", 32'(out_valid), 32'd0);
    chk(req_valid && req_addr == 32'h8000_0008, "t2_next_req", req_addr, 32'h8000_0008);

    // T3: access fault at 8000_0008
    wait_sig(1, "t3_wait_out", n);
    chk(inst == 32'h0000_0013 && fault && pc == 32'h8000_0008, "t3_fault", inst, 32'h0000_0013);
    mem_mode = 0;
    req_ready = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk(req_valid && req_addr == 32'h8000_000C, "t3_after_fault", req_addr, 32'h8000_000C);

    // T4: redirect while waiting, then redirect together with the response
    req_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0101;
    cycle();
    resp_valid = 1'b1; resp_data = 32'h1111_1111;
    cycle();
    chk(!out_valid && req_valid && req_addr == 32'h8000_0100, "t4_redir_wait", req_addr, 32'h8000_0100);
    cycle();
    resp_valid = 1'b1; resp_data = 32'h2222_2222;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    cycle();
    chk(!out_valid && req_valid && req_addr == 32'h8000_0200, "t4_redir_resp", req_addr, 32'h8000_0200);
    cycle();
    resp_valid = 1'b1; resp_data = 32'h0040_0093;
    cycle();
    chk(out_valid && pc == 32'h8000_0200 && inst == 32'h0040_0093, "t4_deliver", pc, 32'h8000_0200);
    mem_mode = 2;
    req_ready = 1'b0;
    cycle();

    // T5: lagging memory latency/throughput, then halt during WAIT
    wait_sig(1, "t5_wait_out", n);
    chk(n == 3, "t5_latency", 32'(n), 32'd3);
    chk(pc == 32'h8000_0204, "t5_pc", pc, 32'h8000_0204);
    wait_sig(0, "t5_wait_req", n2);
    chk(n + n2 == 4, "t5_period", 32'(n + n2), 32'd4);
    cycle();
    cycle();
    halt = 1'b1;
    cycle();
    chk(out_valid && !halted && pc == 32'h8000_0208, "t5_halt_deliver", pc, 32'h8000_0208);
    wait_sig(2, "t5_wait_halt", n);
    chk(n == 1, "t5_halt_delay", 32'(n), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk(halted && !req_valid && !out_valid, "t5_halt_stay", {29'd0, halted, req_valid, out_valid}, 32'd4);
    end

    // T6: reset out of HALT, then asynchronous reset during a stalled REQ
    rst = 1'b0;
    mem_mode = 0;
    req_ready = 1'b0;
    cycle();
    rst = 1'b1;
    resp_valid = 1'b1; resp_data = 32'h3333_3333;
    cycle();
    chk(req_valid && req_addr == 32'h8000_0000 && !halted, "t6_first_req", req_addr, 32'h8000_0000);
    resp_valid = 1'b1;
    cycle();
    cycle();
    chk(req_valid && !out_valid, "t6_req_stall", {30'd0, req_valid, out_valid}, 32'd2);
    #1 rst = 1'b0;
    #1 chk(!req_valid && req_addr == RST_PC, "t6_async_rst", {31'd0, req_valid}, 32'd0);
    cycle();
    rst = 1'b1;
    resp_valid = 1'b1; resp_data = 32'h4444_4444;
    cycle();
    chk(!out_valid && req_valid && req_addr == 32'h8000_0000, "t6_after_rst", req_addr, 32'h8000_0000);
    req_ready = 1'b1;
    cycle();
    resp_valid = 1'b1; resp_data = 32'h0050_0093;
    cycle();
    chk(out_valid && inst == 32'h0050_0093 && pc == 32'h8000_0000, "t6_deliver", inst, 32'h0050_0093);
    cycle();

    // T7: redirect during HOLD, then PC wrap-around
    out_ready = 1'b0;
    cycle();
    resp_valid = 1'b1; resp_data = 32'h0060_0093;
    cycle();
    chk(out_valid && pc == 32'h8000_0004, "t7_hold", pc, 32'h8000_0004);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    chk(!out_valid && req_valid && req_addr == 32'hFFFF_FFFC, "t7_hold_redir", req_addr, 32'hFFFF_FFFC);
    cycle();
    resp_valid = 1'b1; resp_data = 32'h0070_0093;
    cycle();
    chk(out_valid && pc == 32'hFFFF_FFFC && inst == 32'h0070_0093, "t7_top_pc", pc, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    cycle();
    req_ready = 1'b0;
    chk(req_valid && req_addr == 32'h0000_0000, "t7_wrap", req_addr, 32'h0000_0000);
    cycle();
    cycle();
    chk(q.size() == 0 && !outst, "drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
